// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX between N_REQ byte sources; grant is held per frame.
// Optional watchdog abort is compiled in with `UART_TX_ARBITER_WATCHDOG_EN.
module uart_tx_arbiter #(
  parameter int unsigned NB_DATA    = 8,
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned NB_TIMEOUT = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ*NB_DATA-1:0] i_req_data,
  input  logic [N_REQ-1:0]         i_req_last,
  output logic [N_REQ-1:0]         o_req_ready,
  output logic [N_REQ-1:0]         o_grant,
  input  logic                     i_done_tx,
  output logic                     o_tx_start,
  output logic [NB_DATA-1:0]       o_tx_data,
  output logic                     o_busy,
  output logic                     o_timeout
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8 || NB_TIMEOUT < 2) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported N_REQ or NB_TIMEOUT");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT} state_e;

  state_e               state_q;
  logic [N_REQ-1:0]     grant_q;
  logic [PTR_W-1:0]     gidx_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [NB_DATA-1:0]   tx_data_q;
  logic                 last_q;
  logic                 tx_start_q;
  logic                 busy_q;
  logic                 done_prev_q;

  logic                 pick_vld_d;
  logic [PTR_W-1:0]     pick_idx_d;
  logic [NB_DATA-1:0]   req_bytes_c [N_REQ];
  logic                 gnt_valid_c;
  logic                 done_rise_c;
  logic                 wdg_fire_c;

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign req_bytes_c[k] = i_req_data[k*NB_DATA +: NB_DATA];
  end

  assign gnt_valid_c = i_req_valid[gidx_q];
  assign done_rise_c = i_done_tx & ~done_prev_q;

  // Ready is the only combinational output: owner's valid while the byte slot is open.
  assign o_req_ready = (state_q == S_LOAD) ? (grant_q & i_req_valid) : '0;

  assign o_grant    = grant_q;
  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = busy_q;

  // First valid requester after ptr, wrapping.
  always_comb begin
    int unsigned idx;
    pick_vld_d = 1'b0;
    pick_idx_d = '0;
    idx        = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = (32'(ptr_q) + i) % N_REQ;
      if (!pick_vld_d && i_req_valid[PTR_W'(idx)]) begin
        pick_vld_d = 1'b1;
        pick_idx_d = PTR_W'(idx);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      ptr_q       <= PTR_W'(N_REQ - 1);
      tx_data_q   <= '0;
      last_q      <= 1'b0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      done_prev_q <= i_done_tx;
      tx_start_q  <= 1'b0;
      if (wdg_fire_c) begin
        ptr_q   <= gidx_q;
        grant_q <= '0;
        busy_q  <= 1'b0;
        state_q <= S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (pick_vld_d) begin
              gidx_q  <= pick_idx_d;
              grant_q <= N_REQ'(1) << pick_idx_d;
              busy_q  <= 1'b1;
              state_q <= S_LOAD;
            end
          end
          S_LOAD: begin
            if (gnt_valid_c) begin
              tx_data_q  <= req_bytes_c[gidx_q];
              last_q     <= i_req_last[gidx_q];
              tx_start_q <= 1'b1;
              state_q    <= S_SEND;
            end
          end
          S_SEND: state_q <= S_WAIT;
          S_WAIT: begin
            if (done_rise_c) begin
              if (last_q) begin
                ptr_q   <= gidx_q;
                grant_q <= '0;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                state_q <= S_LOAD;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

`ifdef UART_TX_ARBITER_WATCHDOG_EN
  localparam logic [NB_TIMEOUT-1:0] WDG_MAX = '1;

  logic [NB_TIMEOUT-1:0] wdg_cnt_q;
  logic                  in_frame_q;
  logic                  timeout_q;
  logic                  wdg_leave_c;
  logic                  wdg_count_c;

  // Any state change at this edge restarts the count in the new state.
  assign wdg_leave_c = (state_q == S_IDLE) || (state_q == S_SEND) ||
                       ((state_q == S_LOAD) && gnt_valid_c) ||
                       ((state_q == S_WAIT) && done_rise_c);
  assign wdg_count_c = (state_q == S_WAIT) || ((state_q == S_LOAD) && in_frame_q);
  assign wdg_fire_c  = wdg_count_c && !wdg_leave_c &&
                       (wdg_cnt_q == WDG_MAX - NB_TIMEOUT'(1));
  assign o_timeout   = timeout_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wdg_cnt_q  <= '0;
      in_frame_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= wdg_fire_c;
      if (wdg_fire_c || wdg_leave_c) begin
        wdg_cnt_q <= '0;
      end else if (wdg_count_c) begin
        wdg_cnt_q <= wdg_cnt_q + NB_TIMEOUT'(1);
      end
      if (wdg_fire_c || (state_q == S_IDLE)) begin
        in_frame_q <= 1'b0;
      end else if ((state_q == S_WAIT) && done_rise_c && !last_q) begin
        in_frame_q <= 1'b1;
      end
    end
  end
`else
  assign wdg_fire_c = 1'b0;
  assign o_timeout  = 1'b0;
`endif

endmodule
